// File: rtl/tc_array_pkg.sv
// Shared definitions for the timer/counter array: register map, CTRL layout,
// mode and FSM encodings, and the prescaler terminal-count helper.
package tc_array_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 4;
  localparam int CTRL_PS_HI   = 7;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam int PSC_W = 16;

  // Field order matches the CTRL bit positions above (en is bit 0).
  typedef struct packed {
    logic [3:0] ps;
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Prescale counter value on which a tick is issued: 2^ps - 1.
  function automatic logic [PSC_W-1:0] ps_terminal(input logic [3:0] ps);
    return (PSC_W'(1) << ps) - PSC_W'(1);
  endfunction

endpackage

// File: rtl/tc_array_if.sv
// Word-addressed register window between the bus bridge and the timer array.
interface tc_array_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Addr;
  logic              WE;
  logic [31:0]       Din;
  logic [31:0]       Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/tc_array_channel.sv
// One timer channel: CTRL/PRESET/COUNT/PEND registers, prescaler and
// countdown FSM.
//
//   state | meaning
//   IDLE  | stopped, waiting for EN
//   LOAD  | COUNT <= PRESET, prescaler cleared
//   CNT   | counting down on prescaler ticks
//   INT   | expiry: set PEND, then stop (one-shot) or reload
module tc_channel
  import tc_array_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_ctrl,
  input  logic             we_preset,
  input  logic             we_status,
  input  logic [31:0]      din,
  output ctrl_t            ctrl,
  output logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] count,
  output logic             pend,
  output logic             irq
);

  logic [1:0]       state;
  logic [PSC_W-1:0] psc;
  logic             en_eff;
  logic             tick;
  logic             reload;
  logic             unused_din;

  // An EN write takes effect in the same cycle so IDLE->LOAD needs no extra cycle.
  assign en_eff     = we_ctrl ? din[CTRL_EN] : ctrl.en;
  assign tick       = (psc == ps_terminal(ctrl.ps));
  assign reload     = (ctrl.mode == MODE_RELOAD);
  assign irq        = pend & ctrl.im;
  assign unused_din = ^din;

  // CTRL: a software write wins over the hardware EN clear at one-shot expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else if (we_ctrl) begin
      ctrl <= ctrl_t'(din[7:0]);
    end else if (state == ST_INT && !reload) begin
      ctrl.en <= 1'b0;
    end
  end

  // PRESET: only sampled by LOAD, so a write mid-count affects the next run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset <= '0;
    end else if (we_preset) begin
      preset <= din[WIDTH-1:0];
    end
  end

  // Sticky pending flag: the hardware set beats a same-edge write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (state == ST_INT) begin
      pend <= 1'b1;
    end else if (we_status && din[0]) begin
      pend <= 1'b0;
    end
  end

  // Countdown FSM with its prescaler and COUNT register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      psc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_eff) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          psc   <= '0;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_eff) begin
            state <= ST_IDLE;
          end else if (tick) begin
            psc <= '0;
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else begin
              count <= '0;
              state <= ST_INT;
            end
          end else begin
            psc <= psc + PSC_W'(1);
          end
        end
        ST_INT: begin
          state <= reload ? ST_LOAD : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tc_array.sv
// Array of NUM_CH timer channels behind one word-addressed register window.
// Addr[ADDR_W-1:2] picks the channel, Addr[1:0] the register.
module tc_array
  import tc_array_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  tc_array_if.slave         bus,
  output logic              IRQ,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int CH_W = ADDR_W - 2;

  logic [CH_W-1:0]   ch_idx;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] ch_sel;
  logic [31:0]       rd_word [NUM_CH];
  logic [31:0]       dout;

  assign ch_idx  = bus.Addr[ADDR_W-1:2];
  assign reg_sel = bus.Addr[1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ctrl_t            ctrl_q;
    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] count_q;
    logic             pend_q;

    assign ch_sel[g] = (ch_idx == CH_W'(g));

    tc_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .we_ctrl   (bus.WE & ch_sel[g] & (reg_sel == REG_CTRL)),
      .we_preset (bus.WE & ch_sel[g] & (reg_sel == REG_PRESET)),
      .we_status (bus.WE & ch_sel[g] & (reg_sel == REG_STATUS)),
      .din       (bus.Din),
      .ctrl      (ctrl_q),
      .preset    (preset_q),
      .count     (count_q),
      .pend      (pend_q),
      .irq       (irq_vec[g])
    );

    assign rd_word[g] = (reg_sel == REG_CTRL)   ? {24'b0, ctrl_q} :
                        (reg_sel == REG_PRESET) ? 32'(preset_q)   :
                        (reg_sel == REG_COUNT)  ? 32'(count_q)    :
                                                  {31'b0, pend_q};
  end

  // Read mux; channel indices with no channel behind them read as zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) dout = rd_word[i];
    end
  end

  assign bus.Dout = dout;
  assign IRQ      = |irq_vec;

endmodule

// File: doc/tc_array.md
Name: tc_array

Overview:
- Parametrised successor to the single-channel timer/counter: NUM_CH independent countdown channels behind one word-addressed register window, replacing the per-timer instances hung off the bridge.
- Adds a per-channel power-of-two prescaler, a PWM-style auto-reload mode, and a sticky write-1-to-clear interrupt status.
- Exposes a combined IRQ for the CPU HWInt vector plus a per-channel vector.

Parameters:
- NUM_CH, 2, number of timer channels (1..8).
- WIDTH, 32, width of the PRESET and COUNT registers (8..32).
- ADDR_W, 5, word-offset address width; must satisfy 2^(ADDR_W-2) >= NUM_CH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Addr  in  ADDR_W  word offset inside the timer window. Addr[ADDR_W-1:2] selects the channel; Addr[1:0] selects the register.
- WE  in  1  word write strobe, already decoded by the bridge for this window.
- Din  in  32  write data.
- Dout  out  32  read data, combinational from Addr.
- IRQ  out  1  OR of all irq_vec bits.
- irq_vec  out  NUM_CH  per-channel interrupt = pending & CTRL.IM.

Behaviour:
- Register map, per channel:
  - reg 0 CTRL (RW): [0] EN; [2:1] MODE (00 one-shot, 01 auto-reload, 1x reserved, treated as 00); [3] IM; [7:4] PS. Other bits read 0.
  - reg 1 PRESET (RW): WIDTH bits, zero-extended on read.
  - reg 2 COUNT (RO): writes are ignored.
  - reg 3 STATUS: [0] PEND. Reads return PEND. Writing 1 to bit 0 clears it; writing 0 has no effect.
- Address decode: a channel index >= NUM_CH reads 0 and ignores writes.
- Reset: all CTRL, PRESET, COUNT, PEND and prescale counters go to 0; every FSM goes to IDLE; IRQ=0, irq_vec=0. Dout then follows the address (0 for every register).
- Prescaler:
  - Per-channel counter, width 16.
  - tick = 1 when the prescale counter equals 2^PS - 1, after which the counter wraps to 0.
  - PS=0 gives a tick every cycle.
  - The counter clears in LOAD.
- Per-channel FSM, states IDLE, LOAD, CNT, INT, one transition per clk:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if EN=0, go to IDLE with COUNT held.
    - else on tick, if COUNT > 1 then COUNT <= COUNT-1.
    - else on tick (COUNT <= 1): COUNT <= 0; go to INT.
  - INT: PEND <= 1.
    - MODE 00: EN <= 0; go to IDLE.
    - MODE 01: go to LOAD.
- Latency, PS=0, PRESET=N>=1: from the EN write cycle, PEND rises at the clock edge ending cycle N+3 (IDLE, LOAD, N CNT cycles, INT). PRESET=0 behaves as PRESET=1.
- Auto-reload period in clk cycles = (max(N,1) << PS) + 2.
- A PRESET write while in CNT takes effect at the next LOAD only.
- Simultaneous events:
  - Software CTRL write and hardware EN clear in INT on the same edge: the software write wins.
  - STATUS W1C and a PEND set on the same edge: the set wins.
  - Clearing EN mid-count freezes COUNT; re-enabling reloads from PRESET.
- irq_vec[i] = PEND[i] & IM[i], driven registered-state only (no combinational path from Din).
- Asynchronous reset asserted mid-count aborts immediately; no PEND is produced.

Decomposition:
- Shared package holds:
  - register offsets REG_CTRL=0, REG_PRESET=1, REG_COUNT=2, REG_STATUS=3;
  - CTRL bit positions;
  - MODE encodings;
  - FSM state encodings.
- One natural sub-module, tc_channel: a single channel's registers, prescaler and FSM with a local write-enable per register.
- tc_array instantiates tc_channel NUM_CH times with a generate loop, and handles the address decode, the read mux and the IRQ reduction.

Test Plan:
- Reset mid-operation: start ch0 with PRESET=100, assert reset at cycle 20 -> COUNT=0, CTRL=0, IRQ=0 immediately; no later interrupt.
- One-shot: ch0 PRESET=5, write CTRL=0x9 (EN, IM) -> PEND=1 and IRQ=1 after 8 cycles; CTRL reads 0x8; COUNT=0; write STATUS=1 -> IRQ=0.
- Auto-reload with prescaler: ch1 PRESET=3, CTRL=0x2B (EN, MODE01, IM, PS=2) -> PEND sets at a 14-cycle period; irq_vec=2'b10; clearing STATUS on the same edge as a new set leaves PEND=1.
- Masking and independence: ch0 with IM=0 expiring -> PEND=1 but irq_vec[0]=0 and IRQ=0; ch1 keeps counting undisturbed.
- Decode edges: write COUNT=0xFFFF -> no change; read channel index >= NUM_CH -> 0; PRESET write during CNT -> current run unaffected, next reload uses the new value.
